// File: rtl/te_block_serializer.sv
// Trace block serializer: buffers up to N connector blocks per cycle in a circular
// queue and hands them one per cycle to a single-port encoder over valid/ready.
package connector_pkg;
    localparam int unsigned XLEN        = 64;
    localparam int unsigned IRETIRE_LEN = 32;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned PRIV_LEN    = 2;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [XLEN-1:0]        iaddr;
        logic [XLEN-1:0]        cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
    } te_block_t;
endpackage

module te_block_serializer
    import connector_pkg::*;
#(
    parameter int unsigned N     = 1,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [N-1:0]                         valid_i,
    input  logic [N-1:0][IRETIRE_LEN-1:0]        iretire_i,
    input  logic [N-1:0]                         ilastsize_i,
    input  logic [N-1:0][ITYPE_LEN-1:0]          itype_i,
    input  logic [N-1:0][XLEN-1:0]               iaddr_i,
    input  logic [XLEN-1:0]                      cause_i,
    input  logic [XLEN-1:0]                      tval_i,
    input  logic [PRIV_LEN-1:0]                  priv_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [IRETIRE_LEN-1:0]               iretire_o,
    output logic                                 ilastsize_o,
    output logic [ITYPE_LEN-1:0]                 itype_o,
    output logic [XLEN-1:0]                      iaddr_o,
    output logic [XLEN-1:0]                      cause_o,
    output logic [XLEN-1:0]                      tval_o,
    output logic [PRIV_LEN-1:0]                  priv_o,
    output logic                                 overflow_o,
    output logic [CNT_W-1:0]                     drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    if ((DEPTH < N) || ((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 2)) begin : g_param_err
        $error("te_block_serializer: DEPTH must be a power of two >= 2 and >= N");
    end

    te_block_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [OCC_W-1:0]   count_q;
    logic               overflow_q;
    logic [CNT_W-1:0]   drop_cnt_q;

    te_block_t          lane_blk_c [N];
    logic [PTR_W-1:0]   lane_off_c [N];
    logic [31:0]        k_c;
    logic [31:0]        free_c;
    logic               pop_c;
    logic               accept_c;
    logic [SUM_W-1:0]   drop_sum_c;
    te_block_t          head_c;

    // Build per-lane entries and their compacted write offsets (ascending lane order)
    always_comb begin
        k_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lane_off_c[i]           = PTR_W'(k_c);
            lane_blk_c[i]           = '0;
            lane_blk_c[i].iretire   = iretire_i[i];
            lane_blk_c[i].ilastsize = ilastsize_i[i];
            lane_blk_c[i].itype     = itype_i[i];
            lane_blk_c[i].iaddr     = iaddr_i[i];
            lane_blk_c[i].priv      = priv_i;
            if ((itype_i[i] == ITYPE_LEN'(1)) || (itype_i[i] == ITYPE_LEN'(2))) begin
                lane_blk_c[i].cause = cause_i;
                lane_blk_c[i].tval  = tval_i;
            end
            k_c = k_c + 32'(valid_i[i]);
        end
    end

    // A same-cycle pop frees one slot for the incoming group
    always_comb begin
        pop_c      = (count_q != '0) && ready_i;
        free_c     = 32'(DEPTH) - 32'(count_q) + 32'(pop_c);
        accept_c   = (k_c <= free_c);
        drop_sum_c = {1'b0, drop_cnt_q} + SUM_W'(k_c);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (accept_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(k_c);
                count_q  <= count_q + OCC_W'(k_c) - OCC_W'(pop_c);
            end else begin
                count_q    <= count_q - OCC_W'(pop_c);
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum_c[CNT_W] ? '1 : drop_sum_c[CNT_W-1:0];
            end
        end
    end

    // Payload storage carries no reset; stale entries are masked by count_q
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && accept_c) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (valid_i[i]) begin
                    mem_q[wr_ptr_q + lane_off_c[i]] <= lane_blk_c[i];
                end
            end
        end
    end

    always_comb begin
        head_c = '0;
        if (count_q != '0) begin
            head_c = mem_q[rd_ptr_q];
        end
    end

    assign valid_o     = (count_q != '0);
    assign iretire_o   = head_c.iretire;
    assign ilastsize_o = head_c.ilastsize;
    assign itype_o     = head_c.itype;
    assign iaddr_o     = head_c.iaddr;
    assign cause_o     = head_c.cause;
    assign tval_o      = head_c.tval;
    assign priv_o      = head_c.priv;
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_te_block_serializer.sv
// Randomized scoreboard bench for te_block_serializer against a queue-based model.
module tb_te_block_serializer;
    import connector_pkg::*;

    localparam int unsigned N       = 2;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic                           clk_i = 1'b0;
    logic                           rst_i = 1'b1;
    logic                           flush_i = 1'b0;
    logic [N-1:0]                   valid_i = '0;
    logic [N-1:0][IRETIRE_LEN-1:0]  iretire_i = '0;
    logic [N-1:0]                   ilastsize_i = '0;
    logic [N-1:0][ITYPE_LEN-1:0]    itype_i = '0;
    logic [N-1:0][XLEN-1:0]         iaddr_i = '0;
    logic [XLEN-1:0]                cause_i = '0;
    logic [XLEN-1:0]                tval_i = '0;
    logic [PRIV_LEN-1:0]            priv_i = '0;
    logic                           ready_i = 1'b0;
    logic                           valid_o;
    logic [IRETIRE_LEN-1:0]         iretire_o;
    logic                           ilastsize_o;
    logic [ITYPE_LEN-1:0]           itype_o;
    logic [XLEN-1:0]                iaddr_o;
    logic [XLEN-1:0]                cause_o;
    logic [XLEN-1:0]                tval_o;
    logic [PRIV_LEN-1:0]            priv_o;
    logic                           overflow_o;
    logic [CNT_W-1:0]               drop_cnt_o;

    te_block_serializer #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
        .iaddr_i(iaddr_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .valid_o(valid_o), .ready_i(ready_i), .iretire_o(iretire_o),
        .ilastsize_o(ilastsize_o), .itype_o(itype_o), .iaddr_o(iaddr_o),
        .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: expected block stream plus committed occupancy and drop state
    te_block_t mq[$];
    int  occ = 0, occ_nxt = 0;
    int  dcnt = 0, dcnt_nxt = 0;
    bit  ovf = 0, ovf_nxt = 0;
    bit  clr_pend = 0;
    bit  mon_en = 0;
    int  checks = 0, errors = 0;

    logic [IRETIRE_LEN-1:0] s_iret [N];
    logic                   s_ils  [N];
    logic [ITYPE_LEN-1:0]   s_ity  [N];
    logic [XLEN-1:0]        s_addr [N];
    logic [XLEN-1:0]        s_cause = '0, s_tval = '0;
    logic [PRIV_LEN-1:0]    s_priv = '0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic te_block_t model_blk(input int i);
        te_block_t b;
        b.iretire   = s_iret[i];
        b.ilastsize = s_ils[i];
        b.itype     = s_ity[i];
        b.iaddr     = s_addr[i];
        b.priv      = s_priv;
        b.cause     = (s_ity[i] == 3'd1 || s_ity[i] == 3'd2) ? s_cause : '0;
        b.tval      = (s_ity[i] == 3'd1 || s_ity[i] == 3'd2) ? s_tval  : '0;
        return b;
    endfunction

    task automatic set_lane(input int i, input logic [XLEN-1:0] addr,
                            input logic [ITYPE_LEN-1:0] ity, input logic [IRETIRE_LEN-1:0] iret);
        s_addr[i] = addr;
        s_ity[i]  = ity;
        s_iret[i] = iret;
        s_ils[i]  = 1'b0;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < N; i++) begin
            s_addr[i] = {$urandom, $urandom};
            s_ity[i]  = ITYPE_LEN'($urandom_range(0, 7));
            s_iret[i] = $urandom;
            s_ils[i]  = 1'($urandom_range(0, 1));
        end
        s_cause = {$urandom, $urandom};
        s_tval  = {$urandom, $urandom};
        s_priv  = PRIV_LEN'($urandom_range(0, 3));
    endtask

    // One clock: commit last plan, drive new inputs after the edge, plan the next edge
    task automatic step(input bit rst, input bit fl, input logic [N-1:0] v, input bit rdy);
        int k;
        int pop;
        @(posedge clk_i);
        #1;
        occ  = occ_nxt;
        ovf  = ovf_nxt;
        dcnt = dcnt_nxt;
        if (clr_pend) begin
            mq.delete();
            clr_pend = 0;
        end
        rst_i   = rst;
        flush_i = fl;
        valid_i = v;
        ready_i = rdy;
        for (int i = 0; i < N; i++) begin
            iretire_i[i]   = s_iret[i];
            ilastsize_i[i] = s_ils[i];
            itype_i[i]     = s_ity[i];
            iaddr_i[i]     = s_addr[i];
        end
        cause_i = s_cause;
        tval_i  = s_tval;
        priv_i  = s_priv;
        if (rst) begin
            occ_nxt  = 0;
            ovf_nxt  = 0;
            dcnt_nxt = 0;
            clr_pend = 1;
        end else if (fl) begin
            occ_nxt  = 0;
            clr_pend = 1;
        end else begin
            k   = $countones(v);
            pop = (rdy && occ > 0) ? 1 : 0;
            if (k <= DEPTH - occ + pop) begin
                for (int i = 0; i < N; i++) if (v[i]) mq.push_back(model_blk(i));
                occ_nxt = occ + k - pop;
            end else begin
                ovf_nxt  = 1;
                dcnt_nxt = (dcnt + k > CNT_MAX) ? CNT_MAX : dcnt + k;
                occ_nxt  = occ - pop;
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, '0, rdy);
    endtask

    // Monitor: compares head/status every cycle and retires the head on a handshake
    always @(negedge clk_i) begin
        te_block_t got;
        if (mon_en) begin
            got = '{iretire: iretire_o, ilastsize: ilastsize_o, itype: itype_o, iaddr: iaddr_o,
                    cause: cause_o, tval: tval_o, priv: priv_o};
            chk("valid_o", 256'(valid_o), 256'(occ != 0));
            chk("overflow_o", 256'(overflow_o), 256'(ovf));
            chk("drop_cnt_o", 256'(drop_cnt_o), 256'(dcnt));
            if (occ != 0) begin
                if (mq.size() == 0) begin
                    chk("model_underrun", 256'(0), 256'(1));
                end else begin
                    chk("head", 256'(got), 256'(mq[0]));
                    if (ready_i && !rst_i && !flush_i) void'(mq.pop_front());
                end
            end else begin
                chk("idle_zero", 256'(got), 256'(0));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) set_lane(i, '0, '0, '0);
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        mon_en = 1;
        step(0, 0, '0, 0);
        @(negedge clk_i);
        chk("reset_valid", 256'(valid_o), 256'(0));
        chk("reset_drop", 256'(drop_cnt_o), 256'(0));

        // basic single block
        set_lane(0, 64'h8000_0000, 3'd0, 32'd4);
        step(0, 0, 2'b01, 1);
        idle(3, 1);

        // exception payload kept only for itype 1/2
        s_cause = 64'h2; s_tval = 64'hDEAD; s_priv = 2'd3;
        set_lane(0, 64'h1000, 3'd1, 32'd2);
        step(0, 0, 2'b01, 1);
        set_lane(0, 64'h1004, 3'd4, 32'd2);
        step(0, 0, 2'b01, 1);
        idle(3, 1);

        // multi-lane ordering and compaction
        set_lane(0, 64'h100, 3'd0, 32'd1);
        set_lane(1, 64'h200, 3'd0, 32'd1);
        step(0, 0, 2'b11, 1);
        set_lane(1, 64'h300, 3'd2, 32'd1);
        step(0, 0, 2'b10, 1);
        idle(4, 1);

        // fill to DEPTH under back-pressure, then drop one, then pop-assisted push
        for (int i = 0; i < DEPTH; i++) begin
            set_lane(0, 64'h4000 + 64'(i), 3'd0, 32'(i));
            step(0, 0, 2'b01, 0);
        end
        set_lane(0, 64'h4FFF, 3'd0, 32'd9);
        step(0, 0, 2'b01, 0);
        idle(1, 0);
        @(negedge clk_i);
        chk("full_overflow", 256'(overflow_o), 256'(1));
        chk("full_drop_cnt", 256'(drop_cnt_o), 256'(1));
        set_lane(0, 64'h5000, 3'd0, 32'd9);
        step(0, 0, 2'b01, 1);
        idle(DEPTH + 2, 1);

        // wrap-around at 1:1 push/pop
        for (int i = 0; i < 20; i++) begin
            set_lane(0, 64'h6000 + 64'(i), 3'd0, 32'(i));
            step(0, 0, 2'b01, 1);
        end
        idle(3, 1);
        @(negedge clk_i);
        chk("wrap_no_drop", 256'(drop_cnt_o), 256'(1));

        // flush mid-operation keeps overflow state
        for (int i = 0; i < 5; i++) begin
            set_lane(0, 64'h7000 + 64'(i), 3'd0, 32'(i));
            step(0, 0, 2'b01, 0);
        end
        step(0, 1, '0, 0);
        idle(1, 0);
        @(negedge clk_i);
        chk("flush_valid", 256'(valid_o), 256'(0));
        chk("flush_overflow", 256'(overflow_o), 256'(1));

        // reset mid-operation clears everything
        for (int i = 0; i < 5; i++) begin
            set_lane(0, 64'h7100 + 64'(i), 3'd0, 32'(i));
            step(0, 0, 2'b01, 0);
        end
        step(1, 0, '0, 0);
        idle(1, 0);
        @(negedge clk_i);
        chk("rst_valid", 256'(valid_o), 256'(0));
        chk("rst_drop", 256'(drop_cnt_o), 256'(0));

        // random traffic with alternating back-pressure phases, flushes and resets
        for (int c = 0; c < 1500; c++) begin
            bit rdy;
            rand_lanes();
            rdy = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0)      step(1, 0, N'($urandom), rdy);
            else if ($urandom_range(0, 59) == 0)  step(0, 1, N'($urandom), rdy);
            else                                  step(0, 0, N'($urandom), rdy);
        end
        idle(DEPTH + 4, 1);
        @(negedge clk_i);
        chk("drain_empty", 256'(valid_o), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/te_block_serializer.md
Name: te_block_serializer

Overview:
- Sits directly downstream of the CVA6 trace-encoder connector.
- Accepts up to N trace blocks per cycle from the connector's block outputs (valid, iretire, ilastsize, itype, iaddr, plus shared cause/tval/priv).
- Buffers them in a circular queue and hands them to a single-port trace encoder one block per cycle, using a valid/ready handshake.
- Decouples the connector's multi-block bursts from the encoder's back-pressure; the connector itself has no stall input.

Parameters:
- N, 1, number of block lanes per cycle (matches the connector's N).
- DEPTH, 8, queue entries; power of two, DEPTH >= N.
- CNT_W, 16, width of the dropped-block counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous queue clear.
- valid_i  in  N  per-lane block valid.
- iretire_i  in  N x connector_pkg::IRETIRE_LEN  per-lane retired halfword count.
- ilastsize_i  in  N  per-lane last-instruction size.
- itype_i  in  N x connector_pkg::ITYPE_LEN  per-lane itype.
- iaddr_i  in  N x connector_pkg::XLEN  per-lane block address.
- cause_i  in  connector_pkg::XLEN  exception/interrupt cause (shared by all lanes).
- tval_i  in  connector_pkg::XLEN  trap value (shared by all lanes).
- priv_i  in  connector_pkg::PRIV_LEN  privilege level (shared by all lanes).
- valid_o  out  1  head block valid.
- ready_i  in  1  encoder accepts the head block.
- iretire_o  out  IRETIRE_LEN  head iretire.
- ilastsize_o  out  1  head ilastsize.
- itype_o  out  ITYPE_LEN  head itype.
- iaddr_o  out  XLEN  head iaddr.
- cause_o  out  XLEN  head cause.
- tval_o  out  XLEN  head tval.
- priv_o  out  PRIV_LEN  head priv.
- overflow_o  out  1  sticky flag: at least one group was dropped.
- drop_cnt_o  out  CNT_W  number of dropped blocks, saturating.

Behaviour:
- Storage: DEPTH-entry array {iretire, ilastsize, itype, iaddr, cause, tval, priv}.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH)+1 bits.
- Reset (rst_i=1 at a clk edge): pointers, count, overflow_o and drop_cnt_o clear to 0.
  - valid_o=0 and all data outputs read 0 (outputs are gated to 0 when count==0).
  - A reset mid-burst discards all queued entries; no partial output follows.
- Pop: occurs when valid_o && ready_i.
  - rd_ptr+1, count-1 at the clock edge.
  - valid_o = (count != 0); outputs are driven combinationally from array[rd_ptr].
- Push group:
  - k = popcount(valid_i).
  - Valid lanes are compacted and written in ascending lane index at wr_ptr, wr_ptr+1, ... (mod DEPTH).
  - wr_ptr += k and count += k - pop.
- Cause/tval handling: entries with itype 1 or 2 store cause_i and tval_i; all other entries store 0. Every entry stores priv_i.
- Admission: the group is accepted if k <= DEPTH - count + pop; same-cycle pop frees a slot.
- Atomic drop: otherwise the whole group is dropped; no partial write.
  - overflow_o is set and stays set until reset.
  - drop_cnt_o += k, saturating at 2^CNT_W-1.
- Latency: a block pushed at edge t is visible on valid_o after edge t. There is no bypass, so it is never visible in the same cycle.
- Full queue: a simultaneous pop permits a k<=1 push.
- Empty queue: a push with ready_i=1 has no pop, since valid_o was 0.
- flush_i=1: pointers and count go to 0 and any same-cycle push and pop are discarded. overflow_o and drop_cnt_o are kept.
- rst_i has priority over flush_i.
- Handshake rule: while valid_o=1 && ready_i=0, all head outputs stay stable.
- Ordering: blocks leave in strict arrival order, lane 0 before lane N-1 within a cycle.
- Not permitted: DEPTH not a power of two or DEPTH < N is a parameter error; the design must $error at elaboration.

Test Plan:
- Reset/basic: after reset, push one block (lane 0, itype=0, iretire=4, iaddr=0x8000_0000) with ready_i=1 -> valid_o=1 in the next cycle, iaddr_o=0x8000_0000, cause_o=0; valid_o=0 one cycle after that.
- Exception payload: push itype=1, cause_i=0x2, tval_i=0xDEAD -> output cause_o=0x2, tval_o=0xDEAD. Push itype=4 with the same cause_i -> cause_o=0, tval_o=0.
- Multi-lane order (N=2): lanes {0: iaddr 0x100, 1: iaddr 0x200} in one cycle, ready_i=1 -> 0x100 then 0x200 on consecutive cycles. Lanes {0 invalid, 1: 0x300} -> a single entry, 0x300.
- Back-pressure/full (DEPTH=8): ready_i=0, push 8 single blocks -> count=8, head stable.
  - A 9th push -> dropped, overflow_o=1, drop_cnt_o=1.
  - With ready_i=1 in that same cycle -> accepted instead, count stays 8.
- Wrap-around: 20 pushes/pops interleaved at 1:1 -> all 20 iaddr values emerge in order, no drops, pointers wrap twice.
- Flush/reset mid-operation: 5 queued, flush_i=1 -> valid_o=0 the next cycle, overflow_o unchanged. 5 queued, rst_i=1 -> valid_o=0 and drop_cnt_o=0.
